ay8913_envelope: RTL and testbench

Envelope generator for the AY-3-8913 PSG core. Sits directly downstream of the register file and consumes the envelope period (R11/R12) and envelope shape (R13). It also takes a one-cycle restart strobe that the register file raises on every R13 write. It produces the 4-bit envelope level that the amplitude stage selects for any channel whose mode bit (R8–R10 bit 4) is set.

---
 rtl/ay8913_envelope.sv | 165 ++++++++++++++++
 tb/tb_ay8913_envelope.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ay8913_envelope.sv
// ay8913_envelope: envelope generator for the AY-3-8913 PSG core.
// A clk prescaler feeds a period counter; every completed period advances a
// 4-bit step.  The step is turned into a level by the current direction, and at
// the end of each 16-step cycle the latched shape decides whether to freeze,
// repeat or reverse the ramp.

module ay8913_envelope #(
    parameter int PERIOD_BITS   = 16,
    parameter int PRESCALE_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PERIOD_BITS-1:0] period,
    input  logic [3:0]             shape,
    input  logic                   restart,
    output logic [3:0]             level,
    output logic                   holding
);

    // What happens when the 16th step of a cycle completes.
    typedef enum logic [1:0] {
        END_STOP,
        END_HOLD,
        END_REPEAT
    } end_action_t;

    localparam logic [PRESCALE_LOG2-1:0] PRESCALE_ONE = PRESCALE_LOG2'(1);
    localparam logic [PERIOD_BITS-1:0]   PERIOD_ONE   = PERIOD_BITS'(1);

    // Shape bit positions inside {CONT, ATT, ALT, HOLD}.
    localparam int SHAPE_CONT = 3;
    localparam int SHAPE_ATT  = 2;
    localparam int SHAPE_ALT  = 1;
    localparam int SHAPE_HOLD = 0;

    logic [PRESCALE_LOG2-1:0] prescaler;
    logic [PERIOD_BITS-1:0]   pcnt;
    logic [PERIOD_BITS-1:0]   period_eff;
    logic [3:0]               step;
    logic [3:0]               shape_q;
    logic [3:0]               hold_level;
    logic [3:0]               last_level;
    logic                     attack;
    logic                     period_event;
    logic                     period_done;
    logic                     step_advance;
    logic                     cycle_end;
    end_action_t              end_action;

    // A programmed period of zero behaves exactly like a period of one.
    always_comb begin
        period_eff = period;
        if (period == '0) begin
            period_eff = PERIOD_ONE;
        end
    end

    // The prescaler only runs while the envelope is live, so a frozen
    // envelope never generates period events.
    assign period_event = !holding && (prescaler == '1);

    // Greater-or-equal so that shrinking the period below the running count
    // finishes the period at the next event instead of wrapping the counter.
    assign period_done  = pcnt >= (period_eff - PERIOD_ONE);
    assign step_advance = period_event && period_done;
    assign cycle_end    = step_advance && (step == 4'hF);

    // Level shown on the final step of a ramp: 15 when rising, 0 when falling.
    assign last_level   = attack ? 4'hF : 4'h0;

    // Decode the latched shape into the end-of-cycle behaviour.
    always_comb begin
        end_action = END_STOP;
        if (shape_q[SHAPE_CONT]) begin
            if (shape_q[SHAPE_HOLD]) begin
                end_action = END_HOLD;
            end else begin
                end_action = END_REPEAT;
            end
        end
    end

    // Divide clk down to one period-counter tick per 2^PRESCALE_LOG2 cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
        end else if (restart) begin
            prescaler <= '0;
        end else if (!holding) begin
            prescaler <= prescaler + PRESCALE_ONE;
        end
    end

    // Count prescaler events until the programmed period has elapsed.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
        end else if (restart) begin
            pcnt <= '0;
        end else if (period_event) begin
            if (period_done) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + PERIOD_ONE;
            end
        end
    end

    // Advance the step and apply the shape's end-of-cycle rule; a restart
    // latches the new shape and starts a fresh ramp from step 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            step       <= 4'h0;
            shape_q    <= 4'h0;
            attack     <= 1'b0;
            holding    <= 1'b1;
            hold_level <= 4'h0;
        end else if (restart) begin
            step    <= 4'h0;
            shape_q <= shape;
            attack  <= shape[SHAPE_ATT];
            holding <= 1'b0;
        end else if (cycle_end) begin
            case (end_action)
                END_STOP: begin
                    holding    <= 1'b1;
                    hold_level <= 4'h0;
                end
                END_HOLD: begin
                    holding <= 1'b1;
                    if (shape_q[SHAPE_ALT]) begin
                        hold_level <= ~last_level;
                    end else begin
                        hold_level <= last_level;
                    end
                end
                default: begin
                    step <= 4'h0;
                    // Without ALT the direction never changes after restart,
                    // so reloading it from the latched ATT bit keeps it as is.
                    if (shape_q[SHAPE_ALT]) begin
                        attack <= ~attack;
                    end else begin
                        attack <= shape_q[SHAPE_ATT];
                    end
                end
            endcase
        end else if (step_advance) begin
            step <= step + 4'd1;
        end
    end

    // Frozen envelopes show the latched hold level; live ones follow the ramp.
    always_comb begin
        level = hold_level;
        if (!holding) begin
            if (attack) begin
                level = step;
            end else begin
                level = 4'hF - step;
            end
        end
    end

endmodule

// File: tb/tb_ay8913_envelope.sv
// tb_ay8913_envelope: table-driven and sequence checks of the envelope
// generator, with expected outputs queued when stimulus is applied and popped
// when the output is sampled.

module tb_ay8913_envelope;

    logic        clk;
    logic        reset;
    logic [15:0] period;
    logic [3:0]  shape;
    logic        restart;
    logic [3:0]  level;
    logic        holding;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  shape;
        logic [15:0] period;
        int          offset;
        logic [3:0]  level;
        logic        holding;
    } vec_t;

    typedef struct {
        string      tag;
        logic [3:0] level;
        logic       holding;
    } exp_t;

    vec_t vectors[$];
    exp_t exp_q[$];

    ay8913_envelope #(
        .PERIOD_BITS  (16),
        .PRESCALE_LOG2(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .period (period),
        .shape  (shape),
        .restart(restart),
        .level  (level),
        .holding(holding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls the sequence.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got level=%0d holding=%0d", level, holding);
        $fatal(1, "[TB] watchdog");
    end

    task automatic add_vec(input logic [3:0] s, input logic [15:0] p, input int off,
                           input logic [3:0] l, input logic h);
        vec_t v;
        v = '{s, p, off, l, h};
        vectors.push_back(v);
    endtask

    task automatic expect_output(input string tag, input logic [3:0] l, input logic h);
        exp_t e;
        e = '{tag, l, h};
        exp_q.push_back(e);
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset the DUT, then issue one restart strobe; returns just after that edge.
    task automatic apply_stimulus(input logic [3:0] s, input logic [15:0] p, input string tag,
                                  input logic [3:0] l, input logic h);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        period  = p;
        shape   = s;
        restart = 1'b1;
        expect_output(tag, l, h);
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    task automatic pulse_restart(input logic [3:0] s);
        @(negedge clk);
        shape   = s;
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    task automatic check_output();
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard: nothing queued, got level=%0d holding=%0d", level, holding);
        end else begin
            e = exp_q.pop_front();
            if (level !== e.level || holding !== e.holding) begin
                bad++;
                $display("[TB] FAIL %s: got level=%0d holding=%0d, want level=%0d holding=%0d",
                         e.tag, level, holding, e.level, e.holding);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        restart = 1'b0;
        period  = 16'd1;
        shape   = 4'h0;

        // shape, period, cycles after restart edge, level, holding
        add_vec(4'h0, 16'd1,    1, 4'd15, 1'b0);
        add_vec(4'h0, 16'd1,   15, 4'd15, 1'b0);
        add_vec(4'h0, 16'd1,   16, 4'd14, 1'b0);
        add_vec(4'h0, 16'd1,  240, 4'd0,  1'b0);
        add_vec(4'h0, 16'd1,  255, 4'd0,  1'b0);
        add_vec(4'h0, 16'd1,  256, 4'd0,  1'b1);
        add_vec(4'h0, 16'd1, 1300, 4'd0,  1'b1);
        add_vec(4'h4, 16'd1,    1, 4'd0,  1'b0);
        add_vec(4'h4, 16'd1,  241, 4'd15, 1'b0);
        add_vec(4'h4, 16'd1,  256, 4'd0,  1'b1);
        add_vec(4'hE, 16'd0,   16, 4'd1,  1'b0);
        add_vec(4'hE, 16'd0,  255, 4'd15, 1'b0);
        add_vec(4'hE, 16'd0,  256, 4'd15, 1'b0);
        add_vec(4'hE, 16'd0,  272, 4'd14, 1'b0);
        add_vec(4'hE, 16'd0,  512, 4'd0,  1'b0);
        add_vec(4'hE, 16'd0,  528, 4'd1,  1'b0);
        add_vec(4'h8, 16'd1,  256, 4'd15, 1'b0);
        add_vec(4'hC, 16'd1,  256, 4'd0,  1'b0);
        add_vec(4'hA, 16'd1,  256, 4'd0,  1'b0);
        add_vec(4'hA, 16'd1,  272, 4'd1,  1'b0);
        add_vec(4'hB, 16'd2,   31, 4'd15, 1'b0);
        add_vec(4'hB, 16'd2,   32, 4'd14, 1'b0);
        add_vec(4'hB, 16'd2,  511, 4'd0,  1'b0);
        add_vec(4'hB, 16'd2,  512, 4'd15, 1'b1);
        add_vec(4'hD, 16'd1,  256, 4'd15, 1'b1);
        add_vec(4'h9, 16'd1,  256, 4'd0,  1'b1);
        add_vec(4'hF, 16'd1,  256, 4'd0,  1'b1);
        add_vec(4'h0, 16'd3,   47, 4'd15, 1'b0);
        add_vec(4'h0, 16'd3,   48, 4'd14, 1'b0);

        // Out of reset with no restart the envelope stays frozen at 0.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            expect_output($sformatf("idle%0d", i), 4'd0, 1'b1);
            wait_edges(10);
            check_output();
        end

        for (int i = 0; i < vectors.size(); i++) begin
            apply_stimulus(vectors[i].shape, vectors[i].period, $sformatf("vec%0d", i),
                           vectors[i].level, vectors[i].holding);
            wait_edges(vectors[i].offset);
            check_output();
        end

        // Restart in the middle of a rising sawtooth starts the ramp over.
        apply_stimulus(4'hC, 16'd1, "midramp_before", 4'd2, 1'b0);
        wait_edges(40);
        check_output();
        pulse_restart(4'hC);
        expect_output("midramp_edge", 4'd0, 1'b0);
        check_output();
        expect_output("midramp_15", 4'd0, 1'b0);
        wait_edges(15);
        check_output();
        expect_output("midramp_16", 4'd1, 1'b0);
        wait_edges(1);
        check_output();

        // A restart held high keeps re-arming, so the ramp sits at step 0.
        @(negedge clk);
        shape   = 4'hC;
        restart = 1'b1;
        expect_output("held_restart", 4'd0, 1'b0);
        wait_edges(40);
        check_output();
        restart = 1'b0;
        expect_output("held_release", 4'd1, 1'b0);
        wait_edges(16);
        check_output();

        // Maximum period: no advance long after any short-period boundary.
        apply_stimulus(4'h8, 16'hFFFF, "longperiod", 4'd15, 1'b0);
        wait_edges(20000);
        check_output();
        // Shrink period below the running count: next event ends the period.
        period = 16'd3;
        expect_output("shrink_before", 4'd15, 1'b0);
        wait_edges(15);
        check_output();
        expect_output("shrink_event", 4'd14, 1'b0);
        wait_edges(1);
        check_output();
        expect_output("shrink_next", 4'd13, 1'b0);
        wait_edges(48);
        check_output();

        // Reset and restart together: reset wins.
        @(negedge clk);
        reset   = 1'b1;
        restart = 1'b1;
        shape   = 4'h4;
        expect_output("reset_restart", 4'd0, 1'b1);
        wait_edges(1);
        check_output();
        reset   = 1'b0;
        restart = 1'b0;
        expect_output("reset_restart_after", 4'd0, 1'b1);
        wait_edges(100);
        check_output();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
